// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// fetch FSM state encodings and the program counter reset vector.
package busca_instrucao_pkg;

  localparam int LARGURA_END_PADRAO  = 14;
  localparam int LARGURA_DADO_PADRAO = 16;
  localparam int VETOR_RESET         = 0;

  typedef enum logic [1:0] {
    EMITE   = 2'd0,
    CAPTURA = 2'd1,
    SEGURA  = 2'd2
  } estado_t;

endpackage

// File: rtl/busca_instrucao_contador_programa.sv
// Program counter for the fetch unit: synchronous reset to the reset vector,
// jump load, and increment that wraps silently at the top of the address space.
module contador_programa
  import busca_instrucao_pkg::*;
#(
  parameter int LARGURA_END = LARGURA_END_PADRAO
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   carrega,
  input  logic [LARGURA_END-1:0] alvo,
  input  logic                   incrementa,
  output logic [LARGURA_END-1:0] pc
);

  logic [LARGURA_END-1:0] pc_q;
  logic [LARGURA_END-1:0] pc_d;

  // A jump always wins over the increment.
  always_comb begin
    pc_d = pc_q;
    if (carrega) begin
      pc_d = alvo;
    end else if (incrementa) begin
      pc_d = pc_q + LARGURA_END'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= LARGURA_END'(VETOR_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: reads one word from a synchronous RAM and holds it
// behind a valid/ready handshake. Define BUSCA_CONTADOR_EN to add a transfer counter.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int LARGURA_END  = LARGURA_END_PADRAO,
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO
) (
  input  logic                    clock_sistema,
  input  logic                    reset_sistema,
  output logic [LARGURA_END-1:0]  endereco_mem,
  input  logic [LARGURA_DADO-1:0] dados_mem,
  input  logic                    salto_hab,
  input  logic [LARGURA_END-1:0]  salto_alvo,
  output logic [LARGURA_DADO-1:0] instr_saida,
  output logic [LARGURA_END-1:0]  pc_instr,
  output logic                    instr_valida,
  input  logic                    instr_pronta
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [31:0]             contagem_busca
`endif
);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_DADO-1:0] instr_q, instr_d;
  logic [LARGURA_END-1:0]  pc_instr_q, pc_instr_d;
  logic                    valida_q, valida_d;
  logic                    incrementa;
  logic                    transferencia;
  logic [LARGURA_END-1:0]  pc;

  contador_programa #(
    .LARGURA_END(LARGURA_END)
  ) u_contador_programa (
    .clk        (clock_sistema),
    .reset      (reset_sistema),
    .carrega    (salto_hab),
    .alvo       (salto_alvo),
    .incrementa (incrementa),
    .pc         (pc)
  );

  assign endereco_mem  = pc;
  assign transferencia = valida_q & instr_pronta;

  // A jump in CAPTURA leaves the held registers untouched, so the word
  // returned for the old address is simply never presented.
  always_comb begin
    estado_d   = estado_q;
    instr_d    = instr_q;
    pc_instr_d = pc_instr_q;
    valida_d   = valida_q;
    incrementa = 1'b0;
    unique case (estado_q)
      EMITE: begin
        estado_d = CAPTURA;
      end
      CAPTURA: begin
        instr_d    = dados_mem;
        pc_instr_d = pc;
        valida_d   = 1'b1;
        incrementa = 1'b1;
        estado_d   = SEGURA;
      end
      SEGURA: begin
        if (transferencia) begin
          valida_d = 1'b0;
          estado_d = EMITE;
        end
      end
      default: begin
        estado_d = EMITE;
        valida_d = 1'b0;
      end
    endcase
    if (salto_hab) begin
      estado_d   = EMITE;
      valida_d   = 1'b0;
      incrementa = 1'b0;
      instr_d    = instr_q;
      pc_instr_d = pc_instr_q;
    end
  end

  always_ff @(posedge clock_sistema) begin
    if (reset_sistema) begin
      estado_q   <= EMITE;
      instr_q    <= '0;
      pc_instr_q <= '0;
      valida_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
      valida_q   <= valida_d;
    end
  end

  assign instr_saida  = instr_q;
  assign pc_instr     = pc_instr_q;
  assign instr_valida = valida_q;

`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contagem_q, contagem_d;

  // Only handshaked transfers count; a transfer coinciding with a jump still counts.
  always_comb begin
    contagem_d = contagem_q;
    if (transferencia) begin
      contagem_d = contagem_q + 32'd1;
    end
  end

  always_ff @(posedge clock_sistema) begin
    if (reset_sistema) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign contagem_busca = contagem_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao with a synchronous RAM model.
// Counter checks are included when BUSCA_CONTADOR_EN is defined.
module tb_busca_instrucao;

  logic        clock_sistema = 1'b0;
  logic        reset_sistema = 1'b1;
  logic [13:0] endereco_mem;
  logic [15:0] dados_mem;
  logic        salto_hab     = 1'b0;
  logic [13:0] salto_alvo    = '0;
  logic [15:0] instr_saida;
  logic [13:0] pc_instr;
  logic        instr_valida;
  logic        instr_pronta  = 1'b0;
`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contagem_busca;
`endif

  int testes = 0;
  int falhas = 0;

  logic [15:0] mem [0:16383];

  busca_instrucao dut (
    .clock_sistema (clock_sistema),
    .reset_sistema (reset_sistema),
    .endereco_mem  (endereco_mem),
    .dados_mem     (dados_mem),
    .salto_hab     (salto_hab),
    .salto_alvo    (salto_alvo),
    .instr_saida   (instr_saida),
    .pc_instr      (pc_instr),
    .instr_valida  (instr_valida),
    .instr_pronta  (instr_pronta)
`ifdef BUSCA_CONTADOR_EN
    ,
    .contagem_busca(contagem_busca)
`endif
  );

  always #5 clock_sistema = ~clock_sistema;

  // Synchronous-read RAM: data for an address appears one cycle later.
  always @(posedge clock_sistema) dados_mem <= mem[endereco_mem];

  task automatic tick();
    @(posedge clock_sistema);
    #1;
  endtask

  task automatic do_reset();
    reset_sistema = 1'b1;
    salto_hab     = 1'b0;
    tick();
    tick();
    reset_sistema = 1'b0;
  endtask

  task automatic check_word(input string nome, input logic exp_valida,
                            input logic [15:0] exp_instr, input logic [13:0] exp_pc);
    testes++;
    if (instr_valida !== exp_valida || instr_saida !== exp_instr || pc_instr !== exp_pc) begin
      falhas++;
      $display("[TB] FAIL %s: got valida=%b instr=%h pc=%0d, expected valida=%b instr=%h pc=%0d",
               nome, instr_valida, instr_saida, pc_instr, exp_valida, exp_instr, exp_pc);
    end
  endtask

  task automatic test_reset();
    instr_pronta = 1'b0;
    do_reset();
    testes++;
    if (instr_valida !== 1'b0 || instr_saida !== 16'h0000 || pc_instr !== 14'd0 || endereco_mem !== 14'd0) begin
      falhas++;
      $display("[TB] FAIL reset_state: got valida=%b instr=%h pc=%0d end=%0d, expected 0/0000/0/0",
               instr_valida, instr_saida, pc_instr, endereco_mem);
    end
    tick();
    testes++;
    if (instr_valida !== 1'b0) begin
      falhas++;
      $display("[TB] FAIL reset_latency_early: got valida=%b, expected 0", instr_valida);
    end
    tick();
    check_word("reset_first_word", 1'b1, 16'hAAAA, 14'd0);
  endtask

  task automatic test_sequencia();
    logic [15:0] esperado [4];
    esperado = '{16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F};
    do_reset();
    instr_pronta = 1'b1;
    tick();
    tick();
    check_word("seq_word0", 1'b1, esperado[0], 14'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      testes++;
      if (instr_valida !== 1'b0) begin
        falhas++;
        $display("[TB] FAIL seq_gap%0d: got valida=%b, expected 0", k, instr_valida);
      end
      tick();
      tick();
      check_word($sformatf("seq_word%0d", k), 1'b1, esperado[k], 14'(k));
    end
  endtask

  task automatic test_pronta_baixa();
    int erros;
    do_reset();
    instr_pronta = 1'b0;
    tick();
    tick();
    check_word("stall_start", 1'b1, 16'hAAAA, 14'd0);
    erros = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      testes++;
      if (instr_valida !== 1'b1 || instr_saida !== 16'hAAAA || pc_instr !== 14'd0 || endereco_mem !== 14'd1) begin
        falhas++;
        $display("[TB] FAIL stall_hold%0d: got valida=%b instr=%h pc=%0d end=%0d, expected 1/AAAA/0/1",
                 c, instr_valida, instr_saida, pc_instr, endereco_mem);
      end
    end
    instr_pronta = 1'b1;
    tick();
    testes++;
    if (instr_valida !== 1'b0) begin
      falhas++;
      $display("[TB] FAIL stall_release: got valida=%b, expected 0", instr_valida);
    end
    tick();
    tick();
    check_word("stall_next", 1'b1, 16'h5555, 14'd1);
  endtask

  task automatic test_salto_captura();
    do_reset();
    instr_pronta = 1'b0;
    tick();
    salto_hab  = 1'b1;
    salto_alvo = 14'd500;
    tick();
    salto_hab = 1'b0;
    testes++;
    if (instr_valida !== 1'b0 || endereco_mem !== 14'd500) begin
      falhas++;
      $display("[TB] FAIL jump_capture: got valida=%b end=%0d, expected 0/500", instr_valida, endereco_mem);
    end
    tick();
    tick();
    check_word("jump_target", 1'b1, 16'hA5A5, 14'd500);
  endtask

  task automatic test_salto_wrap();
    instr_pronta = 1'b1;
    salto_hab    = 1'b1;
    salto_alvo   = 14'd16383;
    tick();
    salto_hab = 1'b0;
    testes++;
    if (instr_valida !== 1'b0 || endereco_mem !== 14'd16383) begin
      falhas++;
      $display("[TB] FAIL jump_with_transfer: got valida=%b end=%0d, expected 0/16383", instr_valida, endereco_mem);
    end
    tick();
    tick();
    check_word("wrap_top", 1'b1, 16'h5A5A, 14'd16383);
    testes++;
    if (endereco_mem !== 14'd0) begin
      falhas++;
      $display("[TB] FAIL wrap_pc: got end=%0d, expected 0", endereco_mem);
    end
    tick();
    tick();
    tick();
    check_word("wrap_zero", 1'b1, 16'hAAAA, 14'd0);
  endtask

  task automatic test_reset_segura();
    instr_pronta = 1'b1;
    tick();
    tick();
    tick();
    check_word("pre_reset_hold", 1'b1, 16'h5555, 14'd1);
    instr_pronta  = 1'b0;
    reset_sistema = 1'b1;
    tick();
    reset_sistema = 1'b0;
    testes++;
    if (instr_valida !== 1'b0 || endereco_mem !== 14'd0) begin
      falhas++;
      $display("[TB] FAIL reset_mid_hold: got valida=%b end=%0d, expected 0/0", instr_valida, endereco_mem);
    end
    instr_pronta = 1'b1;
    tick();
    tick();
    check_word("restart_word0", 1'b1, 16'hAAAA, 14'd0);
  endtask

`ifdef BUSCA_CONTADOR_EN
  task automatic test_contador();
    do_reset();
    testes++;
    if (contagem_busca !== 32'd0) begin
      falhas++;
      $display("[TB] FAIL count_reset: got %0d, expected 0", contagem_busca);
    end
    instr_pronta = 1'b1;
    repeat (15) tick();
    tick();
    tick();
    check_word("count_sixth", 1'b1, 16'h0000 ^ mem[5], 14'd5);
    instr_pronta = 1'b0;
    salto_hab    = 1'b1;
    salto_alvo   = 14'd7;
    tick();
    salto_hab = 1'b0;
    tick();
    tick();
    testes++;
    if (contagem_busca !== 32'd5) begin
      falhas++;
      $display("[TB] FAIL count_flush: got %0d, expected 5", contagem_busca);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 7 + 16'h1000);
    mem[0]     = 16'hAAAA;
    mem[1]     = 16'h5555;
    mem[2]     = 16'hF0F0;
    mem[3]     = 16'h0F0F;
    mem[4]     = 16'h1234;
    mem[5]     = 16'h4321;
    mem[500]   = 16'hA5A5;
    mem[16383] = 16'h5A5A;

    test_reset();
    test_sequencia();
    test_pronta_baixa();
    test_salto_captura();
    test_salto_wrap();
    test_reset_segura();
`ifdef BUSCA_CONTADOR_EN
    test_contador();
`endif

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter LARGURA_END, default 14, SHALL set the address width (16K words).
REQ-002 Parameter LARGURA_DADO, default 16, SHALL set the instruction/data word width.
REQ-003 clock_sistema  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_sistema  in  1  SHALL be a synchronous, active-high reset.
REQ-005 endereco_mem  out  LARGURA_END  SHALL be the word address driven to the downstream 16K RAM (endereco_mem port).
REQ-006 dados_mem  in  LARGURA_DADO  SHALL be the read data returned by the RAM (saida_dados), valid one cycle after endereco_mem is presented.
REQ-007 salto_hab  in  1  SHALL be the jump request; salto_alvo  in  LARGURA_END  SHALL be the jump target.
REQ-008 instr_saida  out  LARGURA_DADO  SHALL be the held instruction; pc_instr  out  LARGURA_END  SHALL be its address.
REQ-009 instr_valida  out  1  SHALL be the valid signal; instr_pronta  in  1  SHALL be the consumer's ready signal.

Function
REQ-010 The block SHALL hold a program counter pc; endereco_mem SHALL equal pc combinationally at all times; the block never writes memory.
REQ-011 FSM states SHALL be EMITE, CAPTURA, SEGURA.
REQ-012 EMITE: one cycle, address presented; next state SHALL be CAPTURA.
REQ-013 CAPTURA: at the clock edge, the block SHALL register instr_saida<=dados_mem and pc_instr<=pc, and SHALL update pc<=pc+1, instr_valida<=1 and the state to SEGURA.
REQ-014 SEGURA: instr_valida=1 and instr_saida/pc_instr stable until a transfer (instr_valida & instr_pronta at a rising edge).
REQ-015 On transfer the block SHALL update instr_valida<=0 and the state to EMITE; the minimum throughput SHALL be one instruction per 3 cycles.
REQ-016 pc increment SHALL wrap from 2^LARGURA_END-1 (16383) to 0 without a flag.
REQ-017 salto_hab=1 in any state SHALL take effect at the clock edge: pc<=salto_alvo, state<=EMITE, and instr_valida<=0; jump SHALL have priority over increment and capture.
REQ-018 Jump together with a transfer in SEGURA: the transfer SHALL count as completed, then the jump SHALL apply; jump in CAPTURA SHALL discard the capture.
REQ-019 instr_pronta while instr_valida=0 SHALL be ignored.

Reset
REQ-020 reset_sistema=1 at a rising edge SHALL update pc to 0, the state to EMITE, instr_saida to 0, pc_instr to 0, instr_valida to 0 and the counter (REQ-023) to 0; after that edge endereco_mem SHALL be 0.
REQ-021 Reset SHALL override salto_hab and any transfer; reset mid-SEGURA SHALL drop the held instruction.
REQ-022 The first instr_valida=1 after reset release SHALL occur 2 cycles later, carrying word 0.

Configuration
REQ-023 With macro BUSCA_CONTADOR_EN defined, an output contagem_busca [31:0] SHALL count completed transfers and wrap at 2^32; it SHALL not count flushed instructions.
REQ-024 Without BUSCA_CONTADOR_EN, the port and its counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package SHALL hold LARGURA_END/LARGURA_DADO defaults, the state encodings (EMITE, CAPTURA, SEGURA) and the reset vector (0).
REQ-026 Sub-module contador_programa SHALL implement the pc register with sync reset, load (salto) and increment-with-wrap; the FSM and output register SHALL remain in busca_instrucao.

Verification
REQ-027 Reset, RAM preloaded with words 0..3 = AAAA,5555,F0F0,0F0F, instr_pronta=1 held -> instr_saida sequence AAAA,5555,F0F0,0F0F with pc_instr 0..3, one valid every 3 cycles.
REQ-028 instr_pronta=0 for 10 cycles while valid -> instr_saida/pc_instr constant, endereco_mem=pc_instr+1, and no extra fetches.
REQ-029 Jump to 500 (word A5A5) asserted in CAPTURA -> captured word discarded, next valid instr_saida=A5A5 with pc_instr=500.
REQ-030 Jump to 16383 (word 5A5A) -> 5A5A at pc_instr=16383, then pc_instr=0 (wrap).
REQ-031 reset_sistema pulsed during SEGURA -> instr_valida=0 on the next cycle, endereco_mem=0, and the fetch restarts at word 0.
REQ-032 With BUSCA_CONTADOR_EN defined: 5 transfers plus 1 flushed instruction -> contagem_busca=5.
